sprite_rom_arbiter: RTL
=======================

# sprite_rom_arbiter

Round-robin arbiter that lets several sprite renderers share one sprite ROM and its palette lookup, for example the player-1 and player-2 fighter sprites. It issues at most one ROM read per `vga_clk` cycle and tags each read with the requester's ID. It returns each ROM index to the requester that issued the read after the fixed ROM latency. The block sits between the per-fighter pixel address generators and the single `*_rom` instance, which is clocked on the inverted `vga_clk`.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, ≥2.
- `ADDR_W`, 12: ROM address width (64×64 sprite).
- `DATA_W`, 4: ROM word width (palette index).
- `ROM_LAT`, 1: posedge cycles from `rom_addr` driven to `rom_q` valid at the next sampling posedge; ≥1.

Ports:
- `vga_clk`, in, 1: the single clock; all state updates on posedge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `N_REQ`: requester i wants a read this cycle.
- `req_addr`, in, `N_REQ*ADDR_W`: packed addresses; slice i belongs to requester i.
- `req_ready`, out, `N_REQ`: one-hot grant; the read is accepted when `req_valid[i] & req_ready[i]`.
- `rom_addr`, out, `ADDR_W`: address to the shared ROM.
- `rom_q`, in, `DATA_W`: ROM output.
- `rsp_valid`, out, `N_REQ`: one-hot; `rsp_data` belongs to requester i.
- `rsp_data`, out, `DATA_W`: the returned ROM word.
- `rsp_id`, out, `$clog2(N_REQ)`: index of the requester that owns `rsp_data`.

## Operation
- **Grant**
  - Combinational.
  - The winner is the lowest index at or after `last_grant+1`, modulo `N_REQ`, among the requesters with `req_valid` high.
  - `req_ready` is one-hot or zero, and is never high for a requester whose `req_valid` is low.
- **Pointer**
  - The `last_grant` register updates only on a cycle in which a grant occurs.
  - Reset value is `N_REQ-1`, so requester 0 has first priority.
- **Address**
  - `rom_addr` is the granted requester's `req_addr` slice.
  - With no grant, `rom_addr` holds the previous granted address (registered hold); it is 0 after reset.
- **Tag pipeline**
  - `ROM_LAT` stages, each holding {valid, id}.
  - Stage 0 loads {grant_any, grant_id}; every stage shifts each posedge.
  - The last stage drives `rsp_valid`, one-hot-decoded from id and gated by valid, together with `rsp_id`.
  - `rsp_data` equals `rom_q` in the same cycle that `rsp_valid` is asserted; it is don't-care otherwise.
- **No backpressure on responses**: the requester must accept `rsp_data` in the cycle `rsp_valid` is asserted.
- **Held request**
  - A requester that keeps `req_valid` high while it is not granted waits.
  - Worst-case wait is `N_REQ-1` cycles.
- **Reset**
  - Takes effect immediately, including mid-operation.
  - Every in-flight pipeline stage is invalidated; no response is returned for reads issued before reset.
  - While `reset_n`=0: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rom_addr`=0.

## Timing
- Issue throughput: 1 read per cycle in total; with all `N_REQ` requesters continuously valid, each one gets 1 read per `N_REQ` cycles.
- Request-to-response latency is exactly `ROM_LAT` cycles. A grant at posedge t produces `rsp_valid` during cycle t+`ROM_LAT`.
- Simultaneous requests are resolved by the pointer alone; there is no fixed priority after reset.
- The pointer wraps around: with `last_grant`=`N_REQ-1`, the search starts at index 0.
- Back-to-back grants to the same requester are possible only when no other requester is valid.
- The first grant after reset deassertion can occur in the first cycle `reset_n` is high.

## Structure
- Package `sprite_arb_pkg`:
  - `req_id_t`, a `$clog2(N_REQ)`-bit type.
  - `tag_t`, a struct {valid, id}.
  - constant `DEF_ROM_LAT`=1.
- Sub-module `rr_pick`:
  - Inputs: the `req_valid` vector and `last_grant`.
  - Outputs: the one-hot grant, `grant_any` and `grant_id`; purely combinational.
- The top level contains the pointer register, the address hold register, the tag shift register and the response decode.

## Test plan
- **Single requester**: requester 0 valid for 4 cycles, addresses 0x010…0x013, ROM model returns addr[3:0] → `req_ready[0]` high for all 4 cycles; `rsp_valid[0]` with data 0,1,2,3 in cycles 1–4.
- **Contention**: both requesters valid continuously from reset → grants alternate 0,1,0,1; responses arrive 1 cycle later with the matching `rsp_id`.
- **Wrap and pointer hold**:
  - Requester 1 is granted, then idle cycles follow, then both request → requester 0 wins.
  - Then only requester 1 requests for 2 cycles → 2 consecutive grants to requester 1.
- **Latency parameter**: `ROM_LAT`=3 with interleaved requests → every response appears exactly 3 cycles after its grant, with the correct id, and no response is lost at full throughput.
- **Reset mid-stream**:
  - Stimulus: `reset_n` low for 1 cycle while 2 reads are in flight.
  - `rsp_valid` stays 0 for those reads and `rom_addr` goes to 0.
  - Requester 0 is granted first after release.
- **Idle**: no `req_valid` for 10 cycles → `req_ready`=0, `rsp_valid`=0, and `rom_addr` holds its last value.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sprite_arb_pkg
// Brief   : Shared types and constants for the sprite ROM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package sprite_arb_pkg;

  // Default ROM read latency in vga_clk posedges.
  localparam int DEF_ROM_LAT = 1;

  // Requester ids are carried at a fixed width that covers up to 16
  // requesters. The arbiter narrows them to $clog2(N_REQ) bits at its
  // rsp_id port, so a single package serves every N_REQ.
  localparam int REQ_ID_W = 4;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  // One slot of the read-tag pipeline.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage : sprite_arb_pkg
`default_nettype wire

// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : sprite_rom_arbiter_if
// Brief     : Requester, ROM and response bundle of the sprite ROM arbiter.
//             slave = arbiter side; master = renderers plus the ROM.
// Rev       : 1.0  initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [ID_W-1:0]         rsp_id;

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_addr, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_addr, rsp_valid, rsp_data, rsp_id
  );

endinterface : sprite_rom_arbiter_if
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin pick. Searches from last_grant+1
//          (mod N_REQ) upward and grants the first valid requester.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  req_id_t          last_grant,
  output logic [N_REQ-1:0] grant,
  output logic             grant_any,
  output req_id_t          grant_id
);

  // Walk the candidates in priority order; the first valid one wins.
  always_comb begin
    int tgt;
    tgt       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // last_grant < N_REQ, so one subtraction is enough to wrap.
      tgt = int'(last_grant) + 1 + k;
      if (tgt >= N_REQ) tgt = tgt - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_any && (j == tgt) && req_valid[j]) begin
          grant[j]  = 1'b1;
          grant_any = 1'b1;
          grant_id  = req_id_t'(j);
        end
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sprite_rom_arbiter
// Brief  : Shares one sprite ROM between N_REQ renderers. One read per
//          cycle, round-robin grant, tag pipeline returns each ROM word to
//          its requester exactly ROM_LAT cycles after the grant.
// Rev    : 1.0  initial release
// ============================================================================
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  req_valid_gated;
  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  req_id_t           grant_id;

  req_id_t           last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tag_t [ROM_LAT-1:0] tag_q, tag_d;
  tag_t              tag_last;
  logic [N_REQ-1:0]  rsp_valid;
  logic [DATA_W-1:0] rom_word;

  // No grant can be issued while reset is held, even combinationally.
  always_comb begin
    req_valid_gated = bus.req_valid & {N_REQ{reset_n}};
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_valid  (req_valid_gated),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_any  (grant_any),
    .grant_id   (grant_id)
  );

  assign bus.req_ready = grant;

  // Pointer moves only when someone is granted.
  always_comb begin
    last_grant_d = grant_any ? grant_id : last_grant_q;
  end

  // ROM address follows the winner, otherwise holds the last granted one.
  always_comb begin
    addr_d = addr_q;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) addr_d = bus.req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  assign bus.rom_addr = addr_d;

  // Tag shift register: stage 0 captures this cycle's grant.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = {grant_any, grant_id};
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // State registers; reset flushes every in-flight tag.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= req_id_t'(N_REQ - 1);
      addr_q       <= '0;
      tag_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
    end
  end

  // Decode the oldest tag into the one-hot response strobe.
  always_comb begin
    tag_last  = tag_q[ROM_LAT-1];
    rsp_valid = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rsp_valid[j] = tag_last.valid && (tag_last.id == req_id_t'(j));
    end
  end

  // ROM output is already aligned with the last tag stage.
  always_comb begin
    rom_word = bus.rom_q;
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = tag_last.id[ID_W-1:0];
  assign bus.rsp_data  = rom_word;

endmodule : sprite_rom_arbiter
`default_nettype wire
